// File: rtl/hazard_unit.sv
// Hazard unit: combinational EX forwarding selects and load-use stall/flush, plus registered event counters.
// Controls are zero-latency and never wait on anything; counters update one edge after the event.
module hazard_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteW,
    input  logic             RegWriteM,
    input  logic             MemtoRegE,
    input  logic             Match_1E_M,
    input  logic             Match_1E_W,
    input  logic             Match_2E_M,
    input  logic             Match_2E_W,
    input  logic             Match_12D_E,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             LDRstall,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic [WIDTH-1:0] StallCount,
    output logic [WIDTH-1:0] FwdCount
);

    logic fwd_active;

    // Memory stage is checked first so the newest in-flight value wins.
    always_comb begin
        ForwardAE = 2'b00;
        if (Match_1E_M && RegWriteM)
            ForwardAE = 2'b10;
        else if (Match_1E_W && RegWriteW)
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (Match_2E_M && RegWriteM)
            ForwardBE = 2'b10;
        else if (Match_2E_W && RegWriteW)
            ForwardBE = 2'b01;
    end

    assign fwd_active = (ForwardAE != 2'b00) || (ForwardBE != 2'b00);

    // The flush drops MemtoRegE next cycle, so the stall self-terminates without local state.
    assign LDRstall = Match_12D_E & MemtoRegE;
    assign StallF   = LDRstall;
    assign StallD   = LDRstall;
    assign FlushE   = LDRstall;

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
            FwdCount   <= '0;
        end else begin
            StallCount <= StallCount + WIDTH'(LDRstall);
            FwdCount   <= FwdCount + WIDTH'(fwd_active);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; narrow counters so wrap-around is reachable.
module tb_hazard_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         RegWriteW, RegWriteM, MemtoRegE;
    logic         Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic [1:0]   ForwardAE, ForwardBE;
    logic         LDRstall, StallF, StallD, FlushE;
    logic [W-1:0] StallCount, FwdCount;

    logic [W-1:0] exp_stall, exp_fwd;
    int           passed = 0;
    int           total  = 0;

    always #5 clk = ~clk;

    hazard_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .RegWriteW(RegWriteW), .RegWriteM(RegWriteM), .MemtoRegE(MemtoRegE),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Match_12D_E(Match_12D_E),
        .LDRstall(LDRstall), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .StallCount(StallCount), .FwdCount(FwdCount)
    );

    task automatic drive(input logic rww, input logic rwm, input logic mtr,
                         input logic m1m, input logic m1w, input logic m2m,
                         input logic m2w, input logic m12d);
        RegWriteW = rww; RegWriteM = rwm; MemtoRegE = mtr;
        Match_1E_M = m1m; Match_1E_W = m1w; Match_2E_M = m2m; Match_2E_W = m2w;
        Match_12D_E = m12d;
        #1;
    endtask

    // Advance one edge; the caller states which events are active this cycle.
    task automatic tick(input logic stall_ev, input logic fwd_ev);
        if (reset) begin
            exp_stall = '0;
            exp_fwd   = '0;
        end else begin
            exp_stall = exp_stall + W'(stall_ev);
            exp_fwd   = exp_fwd + W'(fwd_ev);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0);
        total++; if (StallCount !== 8'd0) $display("FAIL reset_stallcount: got %0d want 0", StallCount); else passed++;
        total++; if (FwdCount !== 8'd0) $display("FAIL reset_fwdcount: got %0d want 0", FwdCount); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_idle;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if ({ForwardAE, ForwardBE, LDRstall} !== 5'b00000) $display("FAIL idle_comb: got %b want 00000", {ForwardAE, ForwardBE, LDRstall}); else passed++;
        tick(0, 0); tick(0, 0);
        total++; if (StallCount !== 8'd0 || FwdCount !== 8'd0) $display("FAIL idle_counts: got %0d/%0d want 0/0", StallCount, FwdCount); else passed++;
    endtask

    task automatic test_forwarding;
        drive(1, 1, 0, 1, 0, 0, 1, 0);
        total++; if (ForwardAE !== 2'b10) $display("FAIL fwd_a_mem: got %b want 10", ForwardAE); else passed++;
        total++; if (ForwardBE !== 2'b01) $display("FAIL fwd_b_wb: got %b want 01", ForwardBE); else passed++;
        total++; if (LDRstall !== 1'b0) $display("FAIL fwd_nostall: got %b want 0", LDRstall); else passed++;
        tick(0, 1); tick(0, 1); tick(0, 1);
        total++; if (FwdCount !== 8'd3) $display("FAIL fwd_count: got %0d want 3", FwdCount); else passed++;
        drive(0, 1, 0, 0, 0, 1, 0, 0);
        total++; if (ForwardBE !== 2'b10 || ForwardAE !== 2'b00) $display("FAIL fwd_b_mem: got %b/%b want 00/10", ForwardAE, ForwardBE); else passed++;
    endtask

    task automatic test_priority;
        drive(1, 1, 0, 1, 1, 1, 1, 0);
        total++; if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) $display("FAIL prio_mem: got %b/%b want 10/10", ForwardAE, ForwardBE); else passed++;
        drive(1, 0, 0, 1, 1, 1, 1, 0);
        total++; if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) $display("FAIL prio_wb: got %b/%b want 01/01", ForwardAE, ForwardBE); else passed++;
        tick(0, 1);
        total++; if (FwdCount !== 8'd4) $display("FAIL prio_count: got %0d want 4", FwdCount); else passed++;
    endtask

    task automatic test_no_regwrite;
        drive(0, 0, 0, 1, 1, 1, 1, 0);
        total++; if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) $display("FAIL noreg_fwd: got %b/%b want 00/00", ForwardAE, ForwardBE); else passed++;
        tick(0, 0);
        total++; if (FwdCount !== 8'd4) $display("FAIL noreg_count: got %0d want 4", FwdCount); else passed++;
    endtask

    task automatic test_load_use;
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        total++; if ({LDRstall, StallF, StallD, FlushE} !== 4'b1111) $display("FAIL lu_ctrl: got %b want 1111", {LDRstall, StallF, StallD, FlushE}); else passed++;
        total++; if (StallCount !== 8'd0) $display("FAIL lu_before: got %0d want 0", StallCount); else passed++;
        tick(1, 0);
        total++; if (StallCount !== 8'd1) $display("FAIL lu_after: got %0d want 1", StallCount); else passed++;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        total++; if ({LDRstall, StallF, StallD, FlushE} !== 4'b0000) $display("FAIL lu_noload: got %b want 0000", {LDRstall, StallF, StallD, FlushE}); else passed++;
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        total++; if (LDRstall !== 1'b0) $display("FAIL lu_nomatch: got %b want 0", LDRstall); else passed++;
    endtask

    task automatic test_reset_midstall;
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick(1, 0);
        total++; if (StallCount !== 8'd5) $display("FAIL rst_pre: got %0d want 5", StallCount); else passed++;
        reset = 1'b1;
        tick(1, 0);
        total++; if (StallCount !== 8'd0 || FwdCount !== 8'd0) $display("FAIL rst_clear1: got %0d/%0d want 0/0", StallCount, FwdCount); else passed++;
        total++; if (LDRstall !== 1'b1 || FlushE !== 1'b1) $display("FAIL rst_stall_live: got %b%b want 11", LDRstall, FlushE); else passed++;
        drive(1, 0, 1, 0, 1, 0, 0, 1);
        total++; if (ForwardAE !== 2'b01) $display("FAIL rst_fwd_live: got %b want 01", ForwardAE); else passed++;
        tick(1, 1);
        total++; if (StallCount !== 8'd0 || FwdCount !== 8'd0) $display("FAIL rst_clear2: got %0d/%0d want 0/0", StallCount, FwdCount); else passed++;
        reset = 1'b0;
        tick(1, 1);
        total++; if (StallCount !== 8'd1 || FwdCount !== 8'd1) $display("FAIL rst_resume: got %0d/%0d want 1/1", StallCount, FwdCount); else passed++;
    endtask

    task automatic test_wrap;
        reset = 1'b1;
        drive(0, 1, 1, 1, 0, 0, 0, 1);
        tick(0, 0);
        reset = 1'b0;
        for (int i = 0; i < 255; i++) tick(1, 1);
        total++; if (StallCount !== 8'hFF || FwdCount !== 8'hFF) $display("FAIL wrap_max: got %0h/%0h want ff/ff", StallCount, FwdCount); else passed++;
        tick(1, 1);
        total++; if (StallCount !== 8'd0 || FwdCount !== 8'd0) $display("FAIL wrap_zero: got %0h/%0h want 0/0", StallCount, FwdCount); else passed++;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0);
        total++; if (StallCount !== exp_stall || FwdCount !== exp_fwd) $display("FAIL wrap_hold: got %0h/%0h want %0h/%0h", StallCount, FwdCount, exp_stall, exp_fwd); else passed++;
    endtask

    initial begin
        exp_stall = '0;
        exp_fwd   = '0;
        test_reset;
        test_idle;
        test_forwarding;
        test_priority;
        test_no_regwrite;
        test_load_use;
        test_reset_midstall;
        test_wrap;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard unit for the five-stage ARM-style core. Resolves Execute-stage RAW hazards by selecting forwarding sources for both ALU operands from the Memory or Writeback stage. Detects load-use hazards and raises stall/flush controls. Keeps synchronous hazard-event counters for performance monitoring. Sits between the pipeline register match comparators and the datapath forwarding muxes and stage enables.

## Interface
- WIDTH, 32, width of each performance counter.

- clk  input  1  system clock; all registers update on rising edge.
- reset  input  1  synchronous, active-high; clears counters only.
- RegWriteW  input  1  Writeback-stage instruction writes the register file.
- RegWriteM  input  1  Memory-stage instruction writes the register file.
- MemtoRegE  input  1  Execute-stage instruction is a load (LDR).
- Match_1E_M  input  1  Execute source reg 1 equals Memory destination.
- Match_1E_W  input  1  Execute source reg 1 equals Writeback destination.
- Match_2E_M  input  1  Execute source reg 2 equals Memory destination.
- Match_2E_W  input  1  Execute source reg 2 equals Writeback destination.
- ForwardAE  output  2  operand A select: 00 register file, 01 ResultW, 10 ALUOutM.
- ForwardBE  output  2  operand B select, same encoding.
- Match_12D_E  input  1  a Decode source reg equals Execute destination.
- LDRstall  output  1  load-use hazard detected.
- StallF  output  1  hold Fetch PC; equals LDRstall.
- StallD  output  1  hold Decode register; equals LDRstall.
- FlushE  output  1  bubble into Execute; equals LDRstall.
- StallCount  output  WIDTH  number of cycles with LDRstall=1.
- FwdCount  output  WIDTH  number of cycles with any forwarding active (ForwardAE≠00 or ForwardBE≠00).

All ports are connected by name.

## Operation
- ForwardAE: 10 if Match_1E_M & RegWriteM; else 01 if Match_1E_W & RegWriteW; else 00.
- ForwardBE: same rule using Match_2E_M / Match_2E_W.
- Memory stage has priority over Writeback when both match (newest value wins).
- Encoding 11 is never produced.
- LDRstall = Match_12D_E & MemtoRegE. StallF = StallD = FlushE = LDRstall.
- A load-use stall lasts one cycle: FlushE clears MemtoRegE in the following cycle. The unit keeps no stall state.
- Counters: on each rising edge, StallCount += LDRstall and FwdCount += (fwd active). Both are WIDTH-bit unsigned and wrap modulo 2^WIDTH.

## Timing
- Forwarding, LDRstall, StallF, StallD and FlushE are purely combinational, zero latency, and independent of clk and reset.
- While reset=1 they still follow their inputs.
- Reset takes effect at the rising edge while reset=1: StallCount=0 and FwdCount=0. Reset has priority over increment.
- Counter outputs are registered. An event in cycle N appears in the count after edge N.
- Reset asserted mid-stall clears the counters but does not mask LDRstall.
- Inputs must be stable before the clock edge; there is no internal synchronization.

## Test plan
- All inputs 0 -> ForwardAE=00, ForwardBE=00, LDRstall=0; counters unchanged.
- RegWriteM=1, Match_1E_M=1, Match_2E_W=1, RegWriteW=1 -> ForwardAE=10, ForwardBE=01, LDRstall=0; FwdCount +1 per cycle.
- RegWriteM=1, RegWriteW=1, Match_1E_M=Match_1E_W=1 -> ForwardAE=10 (Memory priority). With RegWriteM=0 instead -> ForwardAE=01.
- Matches set but RegWriteM=RegWriteW=0 -> ForwardAE=ForwardBE=00.
- MemtoRegE=1, Match_12D_E=1 -> LDRstall=StallF=StallD=FlushE=1; StallCount 0->1 after one edge. With MemtoRegE=0 -> all 0.
- Pulse reset for 2 cycles after counting 5 stalls -> StallCount=FwdCount=0 on the next edge, while combinational outputs keep tracking inputs. Preload to 2^WIDTH-1 (via events) -> next event wraps to 0.
